// File: rtl/dp_sequencer.sv
// dp_sequencer: loadable micro-sequencer for the 4x32 regfile + ALU32 datapath; one instruction per FETCH/EXEC pair.
// Optional feature: define OVF_TRAP_EN to end a run when the datapath reports Overflow.
module dp_sequencer #(
    parameter int PC_W      = 4,
    parameter int STEP_W    = 8,
    parameter int MAX_STEPS = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 prog_we,
    input  logic [PC_W-1:0]      prog_addr,
    input  logic [12+PC_W-1:0]   prog_data,
    input  logic                 Zero,
    input  logic                 Overflow,
    output logic [2:0]           ALUControl,
    output logic [1:0]           addr1,
    output logic [1:0]           addr2,
    output logic [1:0]           addr3,
    output logic                 wr,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout,
    output logic                 ovf_sticky,
    output logic                 trap,
    output logic [PC_W-1:0]      pc
);
    localparam int IW    = 12 + PC_W;
    localparam int DEPTH = 2 ** PC_W;

    typedef enum logic [1:0] {IDLE, FETCH, EXEC, DONE} state_t;

    state_t            state, state_nx;
    logic [IW-1:0]     mem [DEPTH];
    logic [IW-1:0]     ir;
    logic [STEP_W-1:0] steps;

    logic              ir_wr, ir_brz, ir_halt;
    logic [PC_W-1:0]   ir_target;
    logic              trap_hit, last_step, end_run;

    assign ir_wr     = ir[PC_W+2];
    assign ir_brz    = ir[PC_W+1];
    assign ir_halt   = ir[PC_W];
    assign ir_target = ir[PC_W-1:0];

`ifdef OVF_TRAP_EN
    assign trap_hit = Overflow;
`else
    assign trap_hit = 1'b0;
`endif

    assign last_step = (steps + 1'b1) == STEP_W'(MAX_STEPS);
    assign end_run   = trap_hit | ir_halt | last_step;

    // NOTE: program memory is deliberately left out of reset so a loaded program survives rst.
    always_ff @(posedge clk) begin
        if (prog_we && (state == IDLE || state == DONE))
            mem[prog_addr] <= prog_data;
    end

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ir         <= '0;
            pc         <= '0;
            steps      <= '0;
            timeout    <= 1'b0;
            ovf_sticky <= 1'b0;
            trap       <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (start) begin
                        pc         <= '0;
                        steps      <= '0;
                        timeout    <= 1'b0;
                        ovf_sticky <= 1'b0;
                        trap       <= 1'b0;
                    end
                end
                FETCH: ir <= mem[pc];
                EXEC: begin
                    steps <= steps + 1'b1;
                    if (Overflow)
                        ovf_sticky <= 1'b1;
                    // pc only advances when the run continues, so DONE shows the last executed address
                    if (trap_hit)
                        trap <= 1'b1;
                    else if (!ir_halt) begin
                        if (last_step)
                            timeout <= 1'b1;
                        else
                            pc <= (ir_brz && Zero) ? ir_target : pc + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = FETCH;
            FETCH:   state_nx = EXEC;
            EXEC:    state_nx = end_run ? DONE : FETCH;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        wr   = 1'b0;
        case (state)
            FETCH: busy = 1'b1;
            EXEC: begin
                busy = 1'b1;
                wr   = ir_wr;
            end
            DONE:  done = 1'b1;
            default: ;
        endcase
    end

    assign ALUControl = ir[IW-1 -: 3];
    assign addr1      = ir[IW-4 -: 2];
    assign addr2      = ir[IW-6 -: 2];
    assign addr3      = ir[IW-8 -: 2];

endmodule

// File: tb/tb_dp_sequencer.sv
// Self-checking bench for dp_sequencer: a trace model predicts every cycle of each run from the program and
// the per-step Zero/Overflow plan; directed programs add literal expectations.
module tb_dp_sequencer;
    localparam int PC_W   = 4;
    localparam int STEP_W = 8;
    localparam int MAXS   = 4;
    localparam int IW     = 12 + PC_W;
    localparam int DEPTH  = 2 ** PC_W;
`ifdef OVF_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, start, prog_we, Zero, Overflow;
    logic [PC_W-1:0] prog_addr;
    logic [IW-1:0]   prog_data;
    logic [2:0]      ALUControl;
    logic [1:0]      addr1, addr2, addr3;
    logic            wr, busy, done, timeout, ovf_sticky, trap;
    logic [PC_W-1:0] pc;

    dp_sequencer #(.PC_W(PC_W), .STEP_W(STEP_W), .MAX_STEPS(MAXS)) dut (
        .clk(clk), .rst(rst), .start(start), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .Zero(Zero), .Overflow(Overflow), .ALUControl(ALUControl),
        .addr1(addr1), .addr2(addr2), .addr3(addr3), .wr(wr), .busy(busy), .done(done),
        .timeout(timeout), .ovf_sticky(ovf_sticky), .trap(trap), .pc(pc)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // model state: program image, per-step input plan, values held while idle
    logic [IW-1:0]   mem_m [DEPTH];
    logic            zplan [MAXS];
    logic            oplan [MAXS];
    logic [IW-1:0]   m_ir;
    logic [PC_W-1:0] m_pc;
    logic            m_to, m_ovf, m_trap;

    // expected outputs for the current cycle
    logic            chk_en = 1'b0;
    logic            exp_busy, exp_done, exp_wr, exp_to, exp_ovf, exp_trap;
    logic [IW-1:0]   exp_ir;
    logic [PC_W-1:0] exp_pc;

    // observations from the latest run, used by the literal expectations
    int              obs_done_t;
    logic [31:0]     obs_wr_mask, obs_busy_mask;
    logic [PC_W-1:0] obs_pc [16];

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", busy, exp_busy);
            check("done", done, exp_done);
            check("wr", wr, exp_wr);
            check("alu", ALUControl, exp_ir[IW-1 -: 3]);
            check("addr1", addr1, exp_ir[IW-4 -: 2]);
            check("addr2", addr2, exp_ir[IW-6 -: 2]);
            check("addr3", addr3, exp_ir[IW-8 -: 2]);
            check("pc", pc, exp_pc);
            check("timeout", timeout, exp_to);
            check("ovf_sticky", ovf_sticky, exp_ovf);
            check("trap", trap, exp_trap);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic rbit();
        return ($urandom & 1) != 0;
    endfunction

    function automatic logic ovf_upto(input int n);
        logic a = 1'b0;
        for (int i = 0; i < n; i++) a |= oplan[i];
        return a;
    endfunction

    function automatic logic [IW-1:0] mk(input int alu, input int a1, input int a2, input int a3,
                                         input int w, input int brz, input int halt, input int tgt);
        return {alu[2:0], a1[1:0], a2[1:0], a3[1:0], w[0], brz[0], halt[0], tgt[PC_W-1:0]};
    endfunction

    task automatic set_idle_exp();
        exp_busy = 1'b0; exp_done = 1'b0; exp_wr = 1'b0;
        exp_ir = m_ir; exp_pc = m_pc; exp_to = m_to; exp_ovf = m_ovf; exp_trap = m_trap;
    endtask

    task automatic clear_model();
        m_ir = '0; m_pc = '0; m_to = 1'b0; m_ovf = 1'b0; m_trap = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        clear_model();
        set_idle_exp();
        tick();
        rst = 1'b0;
    endtask

    task automatic load(input int a, input logic [IW-1:0] d);
        prog_we = 1'b1; prog_addr = PC_W'(a); prog_data = d;
        tick();
        mem_m[PC_W'(a)] = d;
        prog_we = 1'b0;
    endtask

    task automatic set_plan(input logic [MAXS-1:0] z, input logic [MAXS-1:0] o);
        for (int i = 0; i < MAXS; i++) begin
            zplan[i] = z[i];
            oplan[i] = o[i];
        end
    endtask

    // mode 0: clean run; 1: random start/prog_we noise; 2: start and prog_we held high while busy
    task automatic run(input int mode);
        logic [IW-1:0]   tir [MAXS];
        logic [PC_W-1:0] tpc [MAXS];
        logic [PC_W-1:0] p;
        int k, j;
        bit tr, to;
        if (mode == 1 && rbit()) begin
            prog_we = 1'b1; prog_addr = '0; prog_data = IW'($urandom);
            mem_m[0] = prog_data;
        end
        p = '0; k = 0; tr = 1'b0; to = 1'b0;
        for (int s = 0; s < MAXS; s++) begin
            tpc[s] = p;
            tir[s] = mem_m[p];
            k = s + 1;
            if (TRAP && oplan[s]) begin tr = 1'b1; break; end
            if (tir[s][PC_W]) break;
            if (k == MAXS) begin to = 1'b1; break; end
            p = (tir[s][PC_W+1] && zplan[s]) ? tir[s][PC_W-1:0] : p + 1'b1;
        end
        start = 1'b1;
        tick();
        start = 1'b0; prog_we = 1'b0;
        obs_done_t = -1; obs_wr_mask = '0; obs_busy_mask = '0;
        for (int t = 1; t <= 2 * k + 2; t++) begin
            if (t <= 2 * k) begin
                j = (t - 1) / 2;
                exp_busy = 1'b1; exp_done = 1'b0; exp_pc = tpc[j];
                exp_to = 1'b0; exp_trap = 1'b0; exp_ovf = ovf_upto(j);
                if (t % 2 == 1) begin
                    if (j == 0) exp_ir = m_ir;
                    else        exp_ir = tir[j-1];
                    exp_wr = 1'b0; Zero = rbit(); Overflow = rbit();
                end else begin
                    exp_ir = tir[j]; exp_wr = tir[j][PC_W+2];
                    Zero = zplan[j]; Overflow = oplan[j];
                end
                if (mode == 1) begin
                    start = rbit(); prog_we = rbit();
                    prog_addr = PC_W'($urandom); prog_data = IW'($urandom);
                end else if (mode == 2) begin
                    start = 1'b1; prog_we = 1'b1; prog_addr = '0; prog_data = '1;
                end
            end else begin
                m_ir = tir[k-1]; m_pc = tpc[k-1]; m_to = to; m_trap = tr; m_ovf = ovf_upto(k);
                set_idle_exp();
                exp_done = (t == 2 * k + 1);
                Zero = rbit(); Overflow = rbit();
                if (t == 2 * k + 1 && mode != 0) begin
                    start = 1'b1;
                    if (mode == 1) begin
                        prog_we = rbit(); prog_addr = PC_W'($urandom); prog_data = IW'($urandom);
                    end
                end
            end
            @(negedge clk);
            if (done && obs_done_t < 0) obs_done_t = t;
            if (wr)   obs_wr_mask[t] = 1'b1;
            if (busy) obs_busy_mask[t] = 1'b1;
            obs_pc[t] = pc;
            tick();
            if (prog_we && t == 2 * k + 1) mem_m[prog_addr] = prog_data;
            start = 1'b0; prog_we = 1'b0;
        end
    endtask

    task automatic load_prog2();
        load(0, mk(1, 1, 3, 2, 1, 0, 0, 0));
        load(1, mk(0, 0, 0, 0, 0, 0, 0, 0));
        load(2, mk(0, 0, 0, 3, 1, 0, 1, 0));
    endtask

    int n_done;

    initial begin
        rst = 1'b1; start = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        Zero = 1'b0; Overflow = 1'b0;
        set_plan('0, '0);
        for (int a = 0; a < DEPTH; a++) mem_m[a] = '0;
        tick();
        clear_model();
        set_idle_exp();
        chk_en = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_wr", wr, 0);
        check("rst_pc", pc, 0);
        check("rst_alu", ALUControl, 0);

        // three-instruction program with a halt
        load_prog2();
        run(0);
        check("p2_done_cycle", obs_done_t, 7);
        check("p2_wr_cycles", obs_wr_mask, 32'h44);
        check("p2_busy_cycles", obs_busy_mask, 32'h7E);
        check("p2_pc", pc, 2);
        check("p2_alu_held", ALUControl, 0);
        check("p2_addr3_held", addr3, 3);

        // reset keeps the program image
        do_reset();
        check("rst2_pc", pc, 0);
        check("rst2_addr3", addr3, 0);
        run(0);
        check("rerun_done_cycle", obs_done_t, 7);
        check("rerun_pc", pc, 2);

        // taken and untaken branch on Zero
        load(0, mk(2, 0, 1, 1, 1, 0, 0, 0));
        load(1, mk(3, 1, 2, 0, 0, 1, 0, 5));
        load(2, mk(0, 0, 0, 0, 0, 0, 1, 0));
        load(5, mk(4, 2, 2, 2, 1, 0, 1, 0));
        set_plan(4'b0010, '0);
        run(0);
        check("brz_taken_fetch_pc", obs_pc[5], 5);
        check("brz_taken_pc", pc, 5);
        set_plan('0, '0);
        run(0);
        check("brz_not_taken_fetch_pc", obs_pc[5], 2);
        check("brz_not_taken_pc", pc, 2);

        // self-loop until the step limit
        load(0, mk(1, 0, 0, 1, 1, 1, 0, 0));
        set_plan('1, '0);
        run(0);
        check("limit_wr_cycles", obs_wr_mask, 32'h154);
        check("limit_done_cycle", obs_done_t, 9);
        check("limit_timeout", timeout, 1);

        // overflow in the first instruction
        load(0, mk(2, 1, 1, 1, 1, 0, 0, 0));
        load(1, mk(3, 2, 2, 2, 1, 0, 0, 0));
        load(2, mk(0, 0, 0, 0, 0, 0, 1, 0));
        set_plan('0, 4'b0001);
        run(0);
        check("ovf_sticky", ovf_sticky, 1);
        check("ovf_trap", trap, TRAP ? 1 : 0);
        check("ovf_done_cycle", obs_done_t, TRAP ? 3 : 7);
        check("ovf_wr_cycles", obs_wr_mask, TRAP ? 32'h4 : 32'h14);

        // start and prog_we while busy are ignored
        load_prog2();
        set_plan('0, '0);
        run(2);
        check("busy_noise_done_cycle", obs_done_t, 7);
        run(0);
        check("mem_kept_done_cycle", obs_done_t, 7);
        check("mem_kept_pc", pc, 2);

        // reset during an EXEC with wr=1
        chk_en = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        @(negedge clk);
        check("midrst_exec_wr", wr, 1);
        check("midrst_exec_busy", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_model();
        set_idle_exp();
        chk_en = 1'b1;
        @(negedge clk);
        check("midrst_wr", wr, 0);
        check("midrst_busy", busy, 0);
        n_done = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done) n_done++;
            tick();
        end
        check("midrst_no_done", n_done, 0);

        // randomized programs, plans and control noise
        for (int r = 0; r < 40; r++) begin
            if (r % 8 == 0) begin
                for (int a = 0; a < DEPTH; a++) load(a, IW'($urandom));
            end else begin
                load(int'($urandom_range(DEPTH - 1, 0)), IW'($urandom));
            end
            for (int s = 0; s < MAXS; s++) begin
                zplan[s] = rbit();
                oplan[s] = ($urandom % 4) == 0;
            end
            run(1);
        end

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
